pll_reset_sequencer: RTL
========================

Name: pll_reset_sequencer

Overview:
- Parametrised lock supervisor and reset sequencer for one or more PLLs in an ECP5 clocking tree.
- Filters and synchronises PLL lock, resets a PLL that stalls, and releases per-domain resets in a fixed staggered order.
- Re-enters reset on any lock loss and counts relock events.
- Clocked by the PLL reference clock (e.g. 25 MHz board oscillator), never by a PLL output.

Parameters:
NUM_PLLS, 1, number of PLL lock inputs supervised (all must be locked)
NUM_DOMAINS, 3, number of downstream reset outputs
PLL_RST_CYCLES, 16, cycles pll_rst is held high per PLL reset pulse
LOCK_TIMEOUT, 65536, max cycles in WAIT_LOCK before re-pulsing pll_rst
LOCK_STABLE, 1024, cycles all locks must stay high before release
STAGGER, 16, cycles between successive domain reset releases
CNT_W, 8, width of relock_count

Ports:
clock  in  1  reference clock
resetn  in  1  asynchronous active-low reset
pll_locked  in  NUM_PLLS  raw PLL LOCK outputs, asynchronous to clock
sw_restart  in  1  single-cycle request to restart full sequence
pll_rst  out  1  active-high reset to all PLLs (RST pin)
domain_rst  out  NUM_DOMAINS  active-high resets, bit 0 released first
ready  out  1  high when in RUN
relock_count  out  CNT_W  lock-loss events since resetn, saturating
state  out  3  current FSM state encoding, for debug

Behaviour:
- Reset is asynchronous and active-low; the rest of the block is single clock.
- resetn low (async), all outputs: pll_rst=1, domain_rst=all 1, ready=0, relock_count=0, state=PLL_RST, all counters 0.
- Lock path:
  - Each pll_locked bit goes through a 2-flop synchroniser (reset value 0).
  - lock_ok = AND of synced bits, so latency is 2 cycles.
- State encodings: PLL_RST=0, WAIT_LOCK=1, STABILIZE=2, RELEASE=3, RUN=4.
- PLL_RST:
  - pll_rst=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK with the counter cleared.
  - domain_rst stays all 1.
- WAIT_LOCK:
  - pll_rst=0.
  - lock_ok=1: go to STABILIZE next cycle, counter=0.
  - Counter reaches LOCK_TIMEOUT-1 without lock: go to PLL_RST (no relock_count change).
- STABILIZE:
  - Counter increments while lock_ok=1.
  - lock_ok=0 at any point: go to WAIT_LOCK, counter cleared (glitch filter).
  - Counter reaches LOCK_STABLE-1: go to RELEASE, counter=0.
- RELEASE:
  - On the cycle where counter == i*STAGGER, domain_rst[i] deasserts in the next registered output, for i = 0..NUM_DOMAINS-1.
  - A released bit stays 0 until a lock loss or restart.
  - After domain NUM_DOMAINS-1 is released: go to RUN; ready=1 from the same cycle state=RUN.
  - lock_ok=0 in RELEASE: handle as a lock loss (see RUN).
- RUN:
  - ready=1; holds until lock loss or restart.
  - Lock loss (lock_ok=0):
    - Next cycle: domain_rst=all 1, ready=0.
    - relock_count increments, saturating at 2^CNT_W-1.
    - Go to WAIT_LOCK, with no PLL reset.
- sw_restart=1 in any state: go to PLL_RST next cycle, domain_rst=all 1, ready=0, PLL_RST counter restarts; relock_count unchanged.
- Simultaneous sw_restart and lock loss: sw_restart wins; relock_count still increments if the state was RELEASE or RUN.
- Counter width: clog2 of max(LOCK_TIMEOUT, LOCK_STABLE, NUM_DOMAINS*STAGGER), minimum 1.
- Asserting outputs:
  - domain_rst and pll_rst are registered, glitch-free.
  - Each consuming domain re-synchronises deassertion of its domain_rst bit locally.
- NUM_DOMAINS=1: RELEASE lasts 1 cycle.
- STAGGER=0 is illegal.

Test Plan:
Params NUM_PLLS=2, NUM_DOMAINS=3, PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, STAGGER=4, CNT_W=2.
- Clean start: release resetn at cycle 0 -> pll_rst high 4 cycles. Raise both locks at cycle 6 -> STABILIZE at cycle 9; domain_rst[0] falls at 17, [1] at 21, [2] at 25; ready=1 thereafter.
- Partial lock: only pll_locked[0] high, held 40 cycles -> pll_rst re-pulses for 4 cycles after 32 cycles in WAIT_LOCK; domain_rst stays 7.
- Glitch filter: 1-cycle low on pll_locked[1] during STABILIZE -> back to WAIT_LOCK, stable counter restarts, release delayed; relock_count stays 0.
- Lock loss in RUN: drop pll_locked[0] -> 3 cycles later domain_rst=7, ready=0, relock_count=1. Relock -> full STABILIZE/RELEASE repeats without pll_rst. Repeat 4 times -> relock_count saturates at 3.
- sw_restart mid-RELEASE: pulse when domain_rst=6 -> next cycle domain_rst=7, pll_rst=1 for 4 cycles, relock_count unchanged.
- Async reset in RUN: drop resetn mid-cycle -> pll_rst=1 and domain_rst=7 immediately (before next edge); relock_count=0.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Lock supervisor and staggered reset sequencer for one or more PLLs.
// Runs from the PLL reference clock so it keeps sequencing while the PLLs are unlocked.
module pll_reset_sequencer #(
  parameter int NUM_PLLS       = 1,
  parameter int NUM_DOMAINS    = 3,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int LOCK_STABLE    = 1024,
  parameter int STAGGER        = 16,
  parameter int CNT_W          = 8
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [NUM_PLLS-1:0]    pll_locked,
  input  logic                   sw_restart,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic [CNT_W-1:0]       relock_count,
  output logic [2:0]             state
);

  // state     | meaning
  // PLL_RST   | pll_rst held high for PLL_RST_CYCLES, all domains in reset
  // WAIT_LOCK | PLL running, waiting for all locks; times out into PLL_RST
  // STABILIZE | all locks high, must stay high LOCK_STABLE cycles
  // RELEASE   | domain resets released one by one, STAGGER cycles apart
  // RUN       | all domains released, ready high
  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  localparam int REL_SPAN = NUM_DOMAINS * STAGGER;
  localparam int MAX_A    = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
  localparam int MAX_B    = (MAX_A > REL_SPAN) ? MAX_A : REL_SPAN;
  localparam int MAX_C    = (MAX_B > PLL_RST_CYCLES) ? MAX_B : PLL_RST_CYCLES;
  localparam int TW       = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [TW-1:0]    RST_LAST   = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0]    WAIT_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0]    STAB_LAST  = TW'(LOCK_STABLE - 1);
  localparam logic [TW-1:0]    REL_LAST   = TW'((NUM_DOMAINS - 1) * STAGGER);
  localparam logic [CNT_W-1:0] RELOCK_MAX = '1;

  logic [NUM_PLLS-1:0]    lock_meta;
  logic [NUM_PLLS-1:0]    lock_sync;
  logic                   lock_ok;
  state_t                 state_q;
  state_t                 state_nxt;
  logic [TW-1:0]          cnt_q;
  logic [TW-1:0]          cnt_nxt;
  logic                   relock_inc;
  logic [NUM_DOMAINS-1:0] domain_rst_nxt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lock_meta <= '0;
      lock_sync <= '0;
    end else begin
      lock_meta <= pll_locked;
      lock_sync <= lock_meta;
    end
  end

  assign lock_ok = &lock_sync;

  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    relock_inc = 1'b0;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_ok) begin
          state_nxt = S_STABILIZE;
          cnt_nxt   = '0;
        end else if (cnt_q == WAIT_LAST) begin
          state_nxt = S_PLL_RST;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      S_STABILIZE: begin
        if (!lock_ok) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt_q == STAB_LAST) begin
          state_nxt = S_RELEASE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!lock_ok) begin
          state_nxt  = S_WAIT_LOCK;
          cnt_nxt    = '0;
          relock_inc = 1'b1;
        end else if (cnt_q == REL_LAST) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!lock_ok) begin
          state_nxt  = S_WAIT_LOCK;
          cnt_nxt    = '0;
          relock_inc = 1'b1;
        end
      end
      default: begin
        state_nxt = S_PLL_RST;
        cnt_nxt   = '0;
      end
    endcase
    // A restart overrides the transition but a coincident lock loss is still counted.
    if (sw_restart) begin
      state_nxt = S_PLL_RST;
      cnt_nxt   = '0;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    domain_rst_nxt = '1;
    if (state_nxt == S_RUN) begin
      domain_rst_nxt = '0;
    end else if (state_nxt == S_RELEASE) begin
      domain_rst_nxt = domain_rst;
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        if (cnt_nxt == TW'(i * STAGGER)) domain_rst_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_PLL_RST;
      cnt_q        <= '0;
      pll_rst      <= 1'b1;
      domain_rst   <= '1;
      ready        <= 1'b0;
      relock_count <= '0;
    end else begin
      state_q    <= state_nxt;
      cnt_q      <= cnt_nxt;
      pll_rst    <= (state_nxt == S_PLL_RST);
      domain_rst <= domain_rst_nxt;
      ready      <= (state_nxt == S_RUN);
      if (relock_inc && (relock_count != RELOCK_MAX)) relock_count <= relock_count + 1'b1;
    end
  end

  assign state = state_q;

endmodule
